// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, line/frame total derivation and sync polarity.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Sync pulses are active-low
  localparam logic SYNC_ACTIVE = 1'b0;

  // {video_on, hsync, vsync} while blanked / in reset
  localparam logic [2:0] DISP_IDLE = {1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE};

  function automatic int unsigned vga_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = vga_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = vga_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages; DEPTH=0 is a combinational bypass.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en_i};
    assign data_o      = data_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) stage_d[i] = stage_q[i];
      if (en_i) begin
        stage_d[0] = data_i;
        for (int i = 1; i < int'(DEPTH); i++) stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, sync decode and delayed outputs.
// Define VGA_SYNC_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_sync
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pixel_tick,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        video_on_d,
  output logic        hsync_d,
  output logic        vsync_d,
`ifdef VGA_SYNC_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       frame_start_q, frame_start_d;
  logic       hsync, vsync;
  logic [2:0] disp, disp_dly;

  // Gated by reset so no tick is seen while reset is held
  assign pixel_tick = (div_q == DIV_LAST) && !reset;

  always_comb begin
    div_d         = pixel_tick ? 4'd0 : div_q + 4'd1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pixel_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Counters reset to the last pixel so the first tick lands on (0,0)
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign frame_start = frame_start_q;
  assign video_on    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hsync = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  assign disp = {video_on, hsync, vsync};

  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE_DLY),
    .RST_VAL(DISP_IDLE)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .en_i  (pixel_tick),
    .data_i(disp),
    .data_o(disp_dly)
  );

  assign {video_on_d, hsync_d, vsync_d} = disp_dly;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default timing, a reduced-size frame and a CLK_DIV=2 / PIPE_DLY=0 build.
`timescale 1ns/1ps
module tb_vga_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rst0, rst1, rst2;
  logic       tick0, von0, vod0, hsd0, vsd0, fs0;
  logic       tick1, von1, vod1, hsd1, vsd1, fs1;
  logic       tick2, von2, vod2, hsd2, vsd2, fs2;
  logic [9:0] x0, y0, x1, y1, x2, y2;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] fc0, fc1, fc2;
`endif

  vga_sync dut0 (
    .clk(clk), .reset(rst0), .pixel_tick(tick0), .x(x0), .y(y0), .video_on(von0),
    .video_on_d(vod0), .hsync_d(hsd0), .vsync_d(vsd0),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_cnt(fc0),
`endif
    .frame_start(fs0)
  );

  // 15 x 10 raster: hsync low x=10..12, vsync low y=7..8
  vga_sync #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .PIPE_DLY(2)
  ) dut1 (
    .clk(clk), .reset(rst1), .pixel_tick(tick1), .x(x1), .y(y1), .video_on(von1),
    .video_on_d(vod1), .hsync_d(hsd1), .vsync_d(vsd1),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_cnt(fc1),
`endif
    .frame_start(fs1)
  );

  vga_sync #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .PIPE_DLY(0)
  ) dut2 (
    .clk(clk), .reset(rst2), .pixel_tick(tick2), .x(x2), .y(y2), .video_on(von2),
    .video_on_d(vod2), .hsync_d(hsd2), .vsync_d(vsd2),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_cnt(fc2),
`endif
    .frame_start(fs2)
  );

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (x0 !== 10'd799 || y0 !== 10'd524) begin
      n_fail++; $display("FAIL reset_xy: x=%0d y=%0d, expected x=799 y=524", x0, y0);
    end
    n_tests++;
    if (tick0 !== 1'b0 || fs0 !== 1'b0 || von0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: tick=%b fs=%b von=%b, expected 0 0 0", tick0, fs0, von0);
    end
    n_tests++;
    if (vod0 !== 1'b0 || hsd0 !== 1'b1 || vsd0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_dly: vod=%b hsd=%b vsd=%b, expected 0 1 1", vod0, hsd0, vsd0);
    end
    n_tests++;
    if (x1 !== 10'd14 || y1 !== 10'd9 || vsd2 !== 1'b1 || tick2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_small: x1=%0d y1=%0d vsd2=%b tick2=%b, expected 14 9 1 0",
                         x1, y1, vsd2, tick2);
    end
`ifdef VGA_SYNC_FRAME_CNT_EN
    n_tests++;
    if (fc0 !== 16'h0000) begin
      n_fail++; $display("FAIL reset_fcnt: frame_cnt=%h, expected 0000", fc0);
    end
`endif
  endtask

  task automatic test_first_tick();
    rst0 = 1'b0;
    #1;
    n_tests++;
    if (tick0 !== 1'b1) begin
      n_fail++; $display("FAIL first_tick_div1: pixel_tick=%b, expected 1", tick0);
    end
    @(negedge clk);
    n_tests++;
    if (x0 !== 10'd0 || y0 !== 10'd0 || fs0 !== 1'b1 || von0 !== 1'b1 || vod0 !== 1'b0) begin
      n_fail++; $display("FAIL first_tick: x=%0d y=%0d fs=%b von=%b vod=%b, expected 0 0 1 1 0",
                         x0, y0, fs0, von0, vod0);
    end
    @(negedge clk);
    n_tests++;
    if (x0 !== 10'd1 || fs0 !== 1'b0 || vod0 !== 1'b0) begin
      n_fail++; $display("FAIL second_tick: x=%0d fs=%b vod=%b, expected 1 0 0", x0, fs0, vod0);
    end
    @(negedge clk);
    n_tests++;
    if (vod0 !== 1'b1) begin
      n_fail++; $display("FAIL third_tick_vod: vod=%b, expected 1", vod0);
    end
  endtask

  task automatic test_full_line();
    int         first_low = -1;
    int         low_cnt   = 0;
    logic [9:0] prev_x;
    logic       von_639   = 1'b0;
    logic       von_640   = 1'b1;
    bit         wrapped   = 1'b0;
    prev_x = x0;
    for (int i = 0; i < 1000 && !wrapped; i++) begin
      @(negedge clk);
      if (hsd0 === 1'b0) begin
        if (first_low < 0) first_low = int'(x0);
        low_cnt++;
      end
      if (x0 == 10'd639) von_639 = von0;
      if (x0 == 10'd640) von_640 = von0;
      if (x0 == 10'd0) wrapped = 1'b1;
      else             prev_x  = x0;
    end
    n_tests++;
    if (!wrapped || prev_x !== 10'd799 || y0 !== 10'd1) begin
      n_fail++; $display("FAIL line_wrap: wrapped=%b last_x=%0d y=%0d, expected 1 799 1",
                         wrapped, prev_x, y0);
    end
    n_tests++;
    if (low_cnt != 96) begin
      n_fail++; $display("FAIL hsync_width: low ticks=%0d, expected 96", low_cnt);
    end
    n_tests++;
    if (first_low != 658) begin
      n_fail++; $display("FAIL hsync_start: first low at x=%0d, expected 658", first_low);
    end
    n_tests++;
    if (von_639 !== 1'b1 || von_640 !== 1'b0) begin
      n_fail++; $display("FAIL video_on_edge: x639=%b x640=%b, expected 1 0", von_639, von_640);
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (x0 == 10'd300) found = 1'b1;
    end
    n_tests++;
    if (!found || y0 !== 10'd1 || vod0 !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: found=%b y=%0d vod=%b, expected 1 1 1", found, y0, vod0);
    end
    rst0 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (x0 !== 10'd799 || y0 !== 10'd524 || fs0 !== 1'b0 || tick0 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_cnt: x=%0d y=%0d fs=%b tick=%b, expected 799 524 0 0",
                         x0, y0, fs0, tick0);
    end
    n_tests++;
    if (vod0 !== 1'b0 || hsd0 !== 1'b1 || vsd0 !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_dly: vod=%b hsd=%b vsd=%b, expected 0 1 1",
                         vod0, hsd0, vsd0);
    end
  endtask

  task automatic test_frames();
    int n_fs = 0;
    int t1 = 0, t2 = 0;
    int low_a = 0, low_b = 0;
    rst1 = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (fs1 === 1'b1) begin
        n_fs++;
        if (n_fs == 1) t1 = i;
        else if (n_fs == 2) t2 = i;
      end
      if (vsd1 === 1'b0) begin
        if (i < 151) low_a++;
        else         low_b++;
      end
    end
    n_tests++;
    if (n_fs != 2 || t1 != 1 || t2 - t1 != 150) begin
      n_fail++; $display("FAIL frame_pulses: count=%0d t1=%0d gap=%0d, expected 2 1 150",
                         n_fs, t1, t2 - t1);
    end
    n_tests++;
    if (low_a != 30 || low_b != 30) begin
      n_fail++; $display("FAIL vsync_width: frame1=%0d frame2=%0d, expected 30 30", low_a, low_b);
    end
`ifdef VGA_SYNC_FRAME_CNT_EN
    n_tests++;
    if (fc1 !== 16'd2) begin
      n_fail++; $display("FAIL frame_cnt_count: frame_cnt=%0d, expected 2", fc1);
    end
`endif
  endtask

`ifdef VGA_SYNC_FRAME_CNT_EN
  task automatic test_frame_cnt_wrap();
    bit found = 1'b0;
    force dut1.frame_cnt_q = 16'hffff;
    @(negedge clk);
    release dut1.frame_cnt_q;
    @(negedge clk);
    n_tests++;
    if (fc1 !== 16'hffff) begin
      n_fail++; $display("FAIL frame_cnt_preload: frame_cnt=%h, expected ffff", fc1);
    end
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (fs1 === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (!found || fc1 !== 16'h0000) begin
      n_fail++; $display("FAIL frame_cnt_wrap: found=%b frame_cnt=%h, expected 1 0000", found, fc1);
    end
  endtask
`endif

  task automatic test_reset_in_sync();
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (vsd1 === 1'b0 && hsd1 === 1'b0) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL sync_overlap: both syncs low found=%b, expected 1", found);
    end
    rst1 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (hsd1 !== 1'b1 || vsd1 !== 1'b1 || vod1 !== 1'b0 || x1 !== 10'd14 || y1 !== 10'd9) begin
      n_fail++; $display("FAIL sync_reset: hsd=%b vsd=%b vod=%b x=%0d y=%0d, expected 1 1 0 14 9",
                         hsd1, vsd1, vod1, x1, y1);
    end
    rst1  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (x1 == 10'd14 && y1 == 10'd9) found = 1'b1;
    end
    // Reset lands on the edge where the tick would have wrapped to (0,0)
    rst1 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (!found || fs1 !== 1'b0 || von1 !== 1'b0) begin
      n_fail++; $display("FAIL no_partial_fs: found=%b fs=%b von=%b, expected 1 0 0",
                         found, fs1, von1);
    end
`ifdef VGA_SYNC_FRAME_CNT_EN
    n_tests++;
    if (fc1 !== 16'h0000) begin
      n_fail++; $display("FAIL frame_cnt_reset: frame_cnt=%h, expected 0000", fc1);
    end
`endif
  endtask

  task automatic test_clk_div();
    logic       exp_tick, exp_fs;
    logic [9:0] exp_x;
    bit         found;
    rst2 = 1'b0;
    #1;
    n_tests++;
    if (tick2 !== 1'b0) begin
      n_fail++; $display("FAIL div2_c0: pixel_tick=%b, expected 0", tick2);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_tick = (k % 2 == 1);
      exp_fs   = (k == 2);
      exp_x    = (k == 1) ? 10'd14 : 10'((k - 2) / 2);
      n_tests++;
      if (tick2 !== exp_tick || x2 !== exp_x || fs2 !== exp_fs) begin
        n_fail++; $display("FAIL div2_step%0d: tick=%b x=%0d fs=%b, expected %b %0d %b",
                           k, tick2, x2, fs2, exp_tick, exp_x, exp_fs);
      end
      if (k == 2) begin
        n_tests++;
        if (y2 !== 10'd0 || vod2 !== 1'b1 || von2 !== 1'b1) begin
          n_fail++; $display("FAIL dly0_visible: y=%0d vod=%b von=%b, expected 0 1 1",
                             y2, vod2, von2);
        end
      end
    end
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (x2 == 10'd10) found = 1'b1;
    end
    n_tests++;
    if (!found || hsd2 !== 1'b0 || vod2 !== 1'b0) begin
      n_fail++; $display("FAIL dly0_hsync_on: found=%b hsd=%b vod=%b, expected 1 0 0",
                         found, hsd2, vod2);
    end
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (x2 == 10'd13) found = 1'b1;
    end
    n_tests++;
    if (!found || hsd2 !== 1'b1) begin
      n_fail++; $display("FAIL dly0_hsync_off: found=%b hsd=%b, expected 1 1", found, hsd2);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_tick();
    test_full_line();
    test_mid_reset();
    test_frames();
`ifdef VGA_SYNC_FRAME_CNT_EN
    test_frame_cnt_wrap();
`endif
    test_reset_in_sync();
    test_clk_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
